// File: rtl/stencil_window_linebuf_ub.sv
// Raster-order line buffer emitting a KH x KW window per pixel; one registered output stage (1-cycle latency).
// Backpressure: in_ready drops while a held window is not taken; a stall freezes all state.
module stencil_window_linebuf_ub #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int KW     = 3,
  parameter int KH     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [KH*KW*DATA_W-1:0]    out_data,
  output logic [15:0]                out_x,
  output logic [15:0]                out_y,
  output logic                       out_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]              col_q, col_d;
  logic [RW-1:0]              row_q, row_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic [KH*KW*DATA_W-1:0]    out_data_q, out_data_d;
  logic [15:0]                out_x_q, out_x_d;
  logic [15:0]                out_y_q, out_y_d;
  logic [DATA_W-1:0]          win_q [KH][KW];
  logic [DATA_W-1:0]          win_d [KH][KW];
  logic [DATA_W-1:0]          v [KH];
  logic                       accept;
  logic                       take;
  logic                       qual;

  assign in_ready = ~rst & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  // flush wins over accept: the pixel on a flush edge never touches any state
  assign take     = accept & ~flush;
  assign qual     = (int'(col_q) >= KW - 1) && (int'(row_q) >= KH - 1);

  generate
    if (KH > 1) begin : g_lb
      logic [DATA_W-1:0] lb_mem [KH-1][IMG_W];

      always_ff @(posedge clk) begin
        if (take) begin
          for (int r = 0; r < KH - 2; r++) begin
            lb_mem[r][col_q] <= lb_mem[r+1][col_q];
          end
          lb_mem[KH-2][col_q] <= in_data;
        end
      end

      always_comb begin
        for (int r = 0; r < KH - 1; r++) begin
          v[r] = lb_mem[r][col_q];
        end
        v[KH-1] = in_data;
      end
    end else begin : g_no_lb
      assign v[0] = in_data;
    end
  endgenerate

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (flush) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    if (take) begin
      for (int r = 0; r < KH; r++) begin
        for (int c = 0; c < KW - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][KW-1] = v[r];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    if (flush) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (take && qual) begin
      out_valid_d = 1'b1;
      out_last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
      out_x_d     = 16'(col_q) - 16'(KW - 1);
      out_y_d     = 16'(row_q) - 16'(KH - 1);
      for (int r = 0; r < KH; r++) begin
        for (int c = 0; c < KW; c++) begin
          out_data_d[(r*KW+c)*DATA_W +: DATA_W] = win_d[r][c];
        end
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      for (int r = 0; r < KH; r++) begin
        for (int c = 0; c < KW; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      win_q       <= win_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule

// File: tb/tb_stencil_window_linebuf_ub.sv
// Bench for stencil_window_linebuf_ub: 64x64 3x3 instance against a frame-image model, plus a 16x4 5x1 instance.
module tb_stencil_window_linebuf_ub;

  localparam int DW = 16;
  localparam int W  = 64;
  localparam int H  = 64;
  localparam int K  = 3;
  localparam int NB = K*K*DW;

  typedef struct {
    logic [NB-1:0] d;
    logic [15:0]   x;
    logic [15:0]   y;
    logic          last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [NB-1:0]   out_data;
  logic [15:0]     out_x, out_y;
  logic            out_last;

  logic            s_flush = 1'b0;
  logic            s_in_valid = 1'b0;
  logic            s_in_ready;
  logic [DW-1:0]   s_in_data = '0;
  logic            s_out_valid;
  logic            s_out_ready = 1'b1;
  logic [5*DW-1:0] s_out_data;
  logic [15:0]     s_out_x, s_out_y;
  logic            s_out_last;

  stencil_window_linebuf_ub #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .KW(K), .KH(K)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_last(out_last)
  );

  stencil_window_linebuf_ub #(.DATA_W(DW), .IMG_W(16), .IMG_H(4), .KW(5), .KH(1)) dut_s (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_x(s_out_x), .out_y(s_out_y), .out_last(s_out_last)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int   img [H][W];
  int   mx = 0, my = 0, n_acc = 0;
  exp_t q [$];
  int   n_win = 0, n_last = 0, cyc = 0, acc22_cyc = -1, first_vld_cyc = -1;
  logic [NB-1:0] first_d, last_d;
  logic [NB-1:0] lit_first, lit_last, lit_f2;
  logic [5*DW-1:0] s_lit_first, s_lit_last, s_first_d, s_last_d;

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: keep the whole accepted frame and cut windows out of it directly.
  task automatic model_accept(input logic [DW-1:0] px);
    exp_t e;
    img[my][mx] = int'(px);
    if (mx >= K-1 && my >= K-1) begin
      e.d = '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          e.d[(r*K+c)*DW +: DW] = DW'(img[my-(K-1)+r][mx-(K-1)+c]);
      e.x = 16'(mx - (K-1));
      e.y = 16'(my - (K-1));
      e.last = (mx == W-1) && (my == H-1);
      q.push_back(e);
    end
    if (mx == 2 && my == 2 && acc22_cyc < 0) acc22_cyc = cyc;
    n_acc++;
    if (mx == W-1) begin
      mx = 0;
      my = (my == H-1) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
    logic ev;
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    @(negedge clk);
    ev = (q.size() != 0);
    chk("out_valid", NB'(out_valid), NB'(ev));
    chk("in_ready", NB'(in_ready), NB'(!ev || ordy));
    if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (ev && out_valid) begin
      chk("out_data", out_data, q[0].d);
      chk("out_x", NB'(out_x), NB'(q[0].x));
      chk("out_y", NB'(out_y), NB'(q[0].y));
      chk("out_last", NB'(out_last), NB'(q[0].last));
    end
    if (out_valid && ordy) begin
      n_win++;
      if (out_last) begin n_last++; last_d = out_data; end
      if (out_x == 0 && out_y == 0) first_d = out_data;
    end
    if (ev && ordy) void'(q.pop_front());
    if (fl) begin
      q.delete(); mx = 0; my = 0;
    end else if (iv && (!ev || ordy)) begin
      model_accept(id);
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic run_pixels(input int n, input int base, input int vp, input int rp);
    int start = n_acc;
    int guard = 0;
    while (n_acc - start < n && guard < 30000) begin
      if ($urandom_range(99) < vp)
        cycle(1'b1, DW'(base + my*W + mx), $urandom_range(99) < rp, 1'b0);
      else
        cycle(1'b0, DW'($urandom), $urandom_range(99) < rp, 1'b0);
      guard++;
    end
    chk("accepts", NB'(n_acc - start), NB'(n));
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 20) begin
      cycle(1'b0, DW'($urandom), 1'b1, 1'b0);
      g++;
    end
    cycle(1'b0, DW'($urandom), 1'b1, 1'b0);
    chk("drain", NB'(q.size()), NB'(0));
  endtask

  task automatic clear_stats();
    n_win = 0; n_last = 0; first_d = '0; last_d = '0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0[9] = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
    int l1[9] = '{3965, 3966, 3967, 4029, 4030, 4031, 4093, 4094, 4095};
    int l2[9] = '{5000, 5001, 5002, 5064, 5065, 5066, 5128, 5129, 5130};
    int p, k;
    logic [5*DW-1:0] se;
    for (int i = 0; i < 9; i++) begin
      lit_first[i*DW +: DW] = DW'(l0[i]);
      lit_last[i*DW +: DW]  = DW'(l1[i]);
      lit_f2[i*DW +: DW]    = DW'(l2[i]);
    end
    for (int i = 0; i < 5; i++) begin
      s_lit_first[i*DW +: DW] = DW'(i);
      s_lit_last[i*DW +: DW]  = DW'(59 + i);
    end

    // reset state
    @(posedge clk); #1;
    chk("rst_out_valid", NB'(out_valid), NB'(0));
    chk("rst_out_last", NB'(out_last), NB'(0));
    chk("rst_out_data", out_data, NB'(0));
    chk("rst_out_x", NB'(out_x), NB'(0));
    chk("rst_out_y", NB'(out_y), NB'(0));
    chk("rst_in_ready", NB'(in_ready), NB'(0));
    chk("rst_s_out_valid", NB'(s_out_valid), NB'(0));
    rst = 1'b0;

    // full-rate ramp frame and first-window latency
    clear_stats();
    run_pixels(W*H, 0, 100, 100);
    drain();
    chk("t1_windows", NB'(n_win), NB'(3844));
    chk("t1_last_count", NB'(n_last), NB'(1));
    chk("t1_first_taps", first_d, lit_first);
    chk("t1_last_taps", last_d, lit_last);
    chk("t2_latency", NB'(first_vld_cyc - acc22_cyc), NB'(1));

    // random valid/ready
    clear_stats();
    run_pixels(W*H, 0, 70, 50);
    drain();
    chk("t3_windows", NB'(n_win), NB'(3844));
    chk("t3_last_count", NB'(n_last), NB'(1));
    chk("t3_first_taps", first_d, lit_first);
    chk("t3_last_taps", last_d, lit_last);

    // back-to-back frames
    clear_stats();
    run_pixels(W*H, 0, 100, 100);
    run_pixels(W*H, 5000, 100, 100);
    drain();
    chk("t4_windows", NB'(n_win), NB'(2*3844));
    chk("t4_f2_first_taps", first_d, lit_f2);

    // flush mid-frame, then a fresh ramp
    run_pixels(1000, 0, 80, 80);
    cycle(1'b1, DW'(16'hBEEF), 1'b0, 1'b1);
    chk("t5_flush_valid", NB'(out_valid), NB'(0));
    clear_stats();
    run_pixels(W*H, 0, 100, 100);
    drain();
    chk("t5_windows", NB'(n_win), NB'(3844));
    chk("t5_first_taps", first_d, lit_first);
    chk("t5_last_taps", last_d, lit_last);

    // asynchronous reset mid-frame
    run_pixels(700, 0, 100, 100);
    #2 rst = 1'b1;
    #1;
    chk("t5_arst_valid", NB'(out_valid), NB'(0));
    chk("t5_arst_data", out_data, NB'(0));
    chk("t5_arst_x", NB'(out_x), NB'(0));
    chk("t5_arst_y", NB'(out_y), NB'(0));
    chk("t5_arst_in_ready", NB'(in_ready), NB'(0));
    q.delete(); mx = 0; my = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_stats();
    run_pixels(W*H, 0, 100, 100);
    drain();
    chk("t5r_windows", NB'(n_win), NB'(3844));
    chk("t5r_first_taps", first_d, lit_first);
    chk("t5r_last_taps", last_d, lit_last);

    // 16x4 image, 5x1 window, no line buffers
    p = 0; k = 0;
    s_first_d = '0; s_last_d = '0;
    for (int c = 0; c < 90; c++) begin
      s_in_valid = (p < 64);
      s_in_data = DW'(p);
      @(negedge clk);
      if (s_out_valid) begin
        for (int t = 0; t < 5; t++) se[t*DW +: DW] = DW'((k/12)*16 + (k%12) + t);
        chk("t6_data", NB'(s_out_data), NB'(se));
        chk("t6_x", NB'(s_out_x), NB'(k % 12));
        chk("t6_y", NB'(s_out_y), NB'(k / 12));
        chk("t6_last", NB'(s_out_last), NB'(k == 47));
        if (k == 0) s_first_d = s_out_data;
        if (s_out_last) s_last_d = s_out_data;
        k++;
      end
      if (s_in_valid && s_in_ready) p++;
      @(posedge clk); #1;
    end
    s_in_valid = 1'b0;
    chk("t6_windows", NB'(k), NB'(48));
    chk("t6_first_taps", NB'(s_first_d), NB'(s_lit_first));
    chk("t6_last_taps", NB'(s_last_d), NB'(s_lit_last));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
